// File: rtl/opcode_issue_queue.sv
// Small FIFO feeding the casez opcode/operand selector stage.
// Screens out undecodable opcodes (opcode[3:1] == 0) and keeps a saturating count of them.
module opcode_issue_queue #(
  parameter int DEPTH = 4,
  parameter int OPW   = 4,
  parameter int DW    = 2,
  parameter int CNTW  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPW-1:0]             in_opcode,
  input  logic [DW-1:0]              in_a,
  input  logic [DW-1:0]              in_b,
  input  logic [DW-1:0]              in_c,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPW-1:0]             out_opcode,
  output logic [DW-1:0]              out_a,
  output logic [DW-1:0]              out_b,
  output logic [DW-1:0]              out_c,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop_pulse,
  output logic [CNTW-1:0]            drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = OPW + 3 * DW;

  logic [BW-1:0] mem [DEPTH];
  logic [BW-1:0] head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;

  logic accept;
  logic is_drop;
  logic do_write;
  logic do_pop;

  // Handshake flags come straight from the registered occupancy, so a pop
  // while full only reopens in_ready on the following cycle.
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign level     = level_q;

  assign accept   = in_valid && in_ready;
  assign is_drop  = (in_opcode[3:1] == 3'b000);
  assign do_write = accept && !is_drop;
  assign do_pop   = out_valid && out_ready;

  // Storage needs no reset; the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= {in_opcode, in_a, in_b, in_c};
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    out_opcode = '0;
    out_a      = '0;
    out_b      = '0;
    out_c      = '0;
    if (out_valid) begin
      out_opcode = head[BW-1 -: OPW];
      out_a      = head[3*DW-1 -: DW];
      out_b      = head[2*DW-1 -: DW];
      out_c      = head[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_write, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= accept && is_drop;
      if (accept && is_drop && (drop_count != {CNTW{1'b1}})) begin
        drop_count <= drop_count + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_opcode_issue_queue.sv
// Scoreboard bench for opcode_issue_queue: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_opcode_issue_queue;

  localparam int DEPTH = 4;
  localparam int CNTMAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_opcode = '0;
  logic [1:0] in_a = '0, in_b = '0, in_c = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_opcode;
  logic [1:0] out_a, out_b, out_c;
  logic [2:0] level;
  logic       drop_pulse;
  logic [7:0] drop_count;

  opcode_issue_queue #(.DEPTH(DEPTH), .OPW(4), .DW(2), .CNTW(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .level(level), .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  // reference model state
  logic [9:0] exp_q[$];
  int mlevel = 0;
  int mcount = 0;
  bit mpulse = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit acc, drp, pop;
    if (reset) begin
      mlevel = 0;
      mcount = 0;
      mpulse = 0;
      exp_q.delete();
    end else begin
      acc = in_valid && (mlevel < DEPTH);
      drp = acc && (in_opcode < 4'd2);
      pop = (mlevel > 0) && out_ready;
      if (acc && !drp) exp_q.push_back({in_opcode, in_a, in_b, in_c});
      mlevel = mlevel + ((acc && !drp) ? 1 : 0) - (pop ? 1 : 0);
      mpulse = drp;
      if (drp && mcount < CNTMAX) mcount = mcount + 1;
    end
  end

  always @(negedge clk) begin
    logic [9:0] got;
    if (started) begin
      chk("level", int'(level), mlevel);
      chk("out_valid", int'(out_valid), (mlevel != 0) ? 1 : 0);
      chk("in_ready", int'(in_ready), (mlevel < DEPTH) ? 1 : 0);
      chk("drop_pulse", int'(drop_pulse), int'(mpulse));
      chk("drop_count", int'(drop_count), mcount);
      if (out_valid) begin
        got = {out_opcode, out_a, out_b, out_c};
        if (exp_q.size() == 0) begin
          chk("head_unexpected", int'(got), -1);
        end else begin
          chk("head_data", int'(got), int'(exp_q[0]));
          if (out_ready && !reset) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] c, input logic r);
    in_valid  = v;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_c      = c;
    out_ready = r;
  endtask

  task automatic idle(input logic r);
    drive(1'b0, 4'h0, 2'd0, 2'd0, 2'd0, r);
  endtask

  initial begin
    reset = 1'b1;
    idle(1'b0);
    step();
    step();
    reset = 1'b0;
    started = 1;

    // 1: push into empty queue appears next cycle
    drive(1'b1, 4'b1000, 2'b00, 2'b01, 2'b10, 1'b0);
    step();
    chk("t1_out_valid", int'(out_valid), 1);
    chk("t1_out_opcode", int'(out_opcode), 8);
    chk("t1_out_a", int'(out_a), 0);
    chk("t1_level", int'(level), 1);
    idle(1'b1);
    step();

    // 2: fill to four, fifth push stalls, drain in order
    idle(1'b0);
    drive(1'b1, 4'b0100, 2'd1, 2'd2, 2'd3, 1'b0); step();
    drive(1'b1, 4'b0010, 2'd2, 2'd3, 2'd0, 1'b0); step();
    drive(1'b1, 4'b1111, 2'd3, 2'd0, 2'd1, 1'b0); step();
    drive(1'b1, 4'b0110, 2'd0, 2'd1, 2'd2, 1'b0); step();
    chk("t2_level_full", int'(level), 4);
    chk("t2_in_ready", int'(in_ready), 0);
    drive(1'b1, 4'b1010, 2'd1, 2'd1, 2'd1, 1'b0); step(); step();
    chk("t2_level_stalled", int'(level), 4);
    chk("t2_head_first", int'(out_opcode), 4);
    idle(1'b1);
    repeat (4) step();
    chk("t2_level_drained", int'(level), 0);

    // 3: two drops
    drive(1'b1, 4'b0000, 2'd1, 2'd1, 2'd1, 1'b0); step();
    chk("t3_pulse0", int'(drop_pulse), 1);
    drive(1'b1, 4'b0001, 2'd2, 2'd2, 2'd2, 1'b0); step();
    chk("t3_pulse1", int'(drop_pulse), 1);
    idle(1'b0); step();
    chk("t3_pulse_off", int'(drop_pulse), 0);
    chk("t3_count", int'(drop_count), 2);
    chk("t3_level", int'(level), 0);
    chk("t3_out_valid", int'(out_valid), 0);

    // 4: steady push+pop at level 2
    drive(1'b1, 4'b0011, 2'd0, 2'd0, 2'd1, 1'b0); step();
    drive(1'b1, 4'b0101, 2'd1, 2'd0, 2'd0, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'($urandom_range(2, 15)), 2'($urandom), 2'($urandom), 2'($urandom), 1'b1);
      step();
    end
    chk("t4_level", int'(level), 2);
    idle(1'b1); step(); step();

    // 5: saturate the drop counter
    drive(1'b1, 4'b0001, 2'd0, 2'd0, 2'd0, 1'b0);
    repeat (260) step();
    chk("t5_count_sat", int'(drop_count), 255);
    chk("t5_pulse", int'(drop_pulse), 1);

    // 6: reset during push+pop at level 3
    drive(1'b1, 4'b1000, 2'd1, 2'd2, 2'd3, 1'b0);
    repeat (3) step();
    chk("t6_level_pre", int'(level), 3);
    reset = 1'b1;
    drive(1'b1, 4'b1100, 2'd3, 2'd3, 2'd3, 1'b1);
    step();
    reset = 1'b0;
    idle(1'b0);
    chk("t6_level", int'(level), 0);
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_count", int'(drop_count), 0);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(2, 15));
      drive(1'($urandom_range(0, 2) != 0), op, 2'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom_range(0, 2) == 0 ? 0 : 1));
      if (i % 4 == 0) out_ready = 1'($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle(1'b1);
    repeat (8) step();
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
